// File: rtl/ramp_sequencer_pkg.sv
// rtl/ramp_sequencer_pkg.sv - shared types and helpers for the ramp sequencer
package ramp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RAMP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CONV_CNT_W = 16;

  function automatic logic [31:0] gray_encode(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/ramp_sequencer_if.sv
// rtl/ramp_sequencer_if.sv - control and analog-side signal bundle of the ramp sequencer
interface ramp_sequencer_if #(
  parameter int WIDTH = 8
);
  import ramp_seq_pkg::*;

  logic                  start;
  logic                  cont;
  logic                  abort;
  logic                  comp;
  logic [WIDTH-1:0]      counter;
  logic                  ramp_rst;
  logic                  ramp_en;
  logic                  sampler_rst;
  logic                  busy;
  logic                  done;
  logic                  no_cross;
  logic [CONV_CNT_W-1:0] conv_cnt;

  modport master (
    output start, cont, abort, comp,
    input  counter, ramp_rst, ramp_en, sampler_rst, busy, done, no_cross, conv_cnt
  );

  modport slave (
    input  start, cont, abort, comp,
    output counter, ramp_rst, ramp_en, sampler_rst, busy, done, no_cross, conv_cnt
  );

endinterface

// File: rtl/ramp_step_timer.sv
// rtl/ramp_step_timer.sv - reloadable down-counter; tick marks the last cycle of each interval
module ramp_step_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] period,
  output logic          tick
);

  logic [CW-1:0] cnt;

  // period holds interval length minus one; auto-reloads after each tick
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || tick) begin
      cnt <= period;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/ramp_sequencer.sv
// rtl/ramp_sequencer.sv - single-slope ADC conversion sequencer (RESET, RAMP, DONE)
// Define RAMP_SEQ_GRAY_COUNT_EN to present counter as Gray code of the binary ramp code.
module ramp_sequencer
  import ramp_seq_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int STEP_CYCLES   = 2
) (
  input logic             clk,
  input logic             rst,
  ramp_sequencer_if.slave bus
);

  localparam int MAXC = (SETTLE_CYCLES > STEP_CYCLES) ? SETTLE_CYCLES : STEP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0]    SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]    STEP_LD   = CW'(STEP_CYCLES - 1);
  localparam logic [WIDTH-1:0] CODE_LAST = '1;

  state_t                state, next_state;
  logic [WIDTH-1:0]      bin, bin_d, counter_d;
  logic                  crossed, crossed_d;
  logic                  no_cross_d;
  logic [CONV_CNT_W-1:0] conv_cnt_d;
  logic                  ramp_rst_d, ramp_en_d, sampler_rst_d, busy_d, done_d;
  logic                  tick, load;
  logic [CW-1:0]         period;

  assign load   = (next_state != state);
  assign period = (next_state == RESET) ? SETTLE_LD : STEP_LD;

  ramp_step_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .period (period),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bin             <= '0;
      crossed         <= 1'b0;
      bus.counter     <= '0;
      bus.ramp_rst    <= 1'b0;
      bus.ramp_en     <= 1'b0;
      bus.sampler_rst <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.no_cross    <= 1'b0;
      bus.conv_cnt    <= '0;
    end else begin
      state           <= next_state;
      bin             <= bin_d;
      crossed         <= crossed_d;
      bus.counter     <= counter_d;
      bus.ramp_rst    <= ramp_rst_d;
      bus.ramp_en     <= ramp_en_d;
      bus.sampler_rst <= sampler_rst_d;
      bus.busy        <= busy_d;
      bus.done        <= done_d;
      bus.no_cross    <= no_cross_d;
      bus.conv_cnt    <= conv_cnt_d;
    end
  end

  always_comb begin
    next_state = state;
    if (bus.abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) next_state = RESET;
        RESET:   if (tick) next_state = RAMP;
        RAMP:    if (tick && (bin == CODE_LAST)) next_state = DONE;
        DONE:    next_state = bus.cont ? RESET : IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs are computed from next_state so the registered outputs line up with state
  always_comb begin
    bin_d = '0;
    if ((next_state == RAMP) && (state == RAMP)) begin
      bin_d = tick ? bin + 1'b1 : bin;
    end

`ifdef RAMP_SEQ_GRAY_COUNT_EN
    counter_d = WIDTH'(gray_encode(32'(bin_d)));
`else
    counter_d = bin_d;
`endif

    crossed_d = crossed;
    if ((next_state == RESET) && (state != RESET)) begin
      crossed_d = 1'b0;
    end else if ((state == RAMP) && bus.comp) begin
      crossed_d = 1'b1;
    end

    no_cross_d = bus.no_cross;
    conv_cnt_d = bus.conv_cnt;
    if (next_state == DONE) begin
      no_cross_d = ~crossed_d;
      conv_cnt_d = bus.conv_cnt + 1'b1;
    end

    ramp_rst_d    = (next_state == RESET);
    sampler_rst_d = (next_state == RESET);
    ramp_en_d     = (next_state == RAMP);
    busy_d        = (next_state != IDLE);
    done_d        = (next_state == DONE);
  end

endmodule
